// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-controller <-> unified-memory line interface.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Counter preload on acceptance; the count runs down to 1 before DONE.
  function automatic logic [3:0] latency_load(input int latency);
    return 4'(latency - 1);
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Single-port line RAM with synchronous read and registered output.
module line_mem_array #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // The output register only moves on an enabled read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Responder for line reads/writes: one request at a time, fixed latency, one-cycle rdy pulse.
module unified_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic done_rd;
  logic done_wr;
  logic last_busy;

  assign done_rd   = (state_q == ST_DONE) && (op_q == OP_RD);
  assign done_wr   = (state_q == ST_DONE) && (op_q == OP_WR);
  assign last_busy = (state_q == ST_BUSY) && (cnt_q == 4'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (we || re) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = we ? OP_WR : OP_RD;
          cnt_d   = latency_load(LATENCY);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (op_q == OP_RD) begin
          rd_data_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= OP_RD;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Reads launch on the last BUSY cycle so data is ready in DONE; writes commit as DONE ends.
  // Gating with rst drops a pending write when reset lands on the DONE cycle.
  assign mem_en = !rst && ((last_busy && (op_q == OP_RD)) || done_wr);
  assign mem_we = !rst && done_wr;

  line_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign rd_data = done_rd ? mem_rdata : rd_data_q;
  assign rdy     = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench: scoreboard for the LATENCY=4 responder, hand sequence for a LATENCY=2 build.
module tb_unified_mem_responder;

   localparam int AW = 14;
   localparam int DW = 64;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   logic [AW-1:0] addr;
   logic re, we;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdData;
   logic rdy, busy;

   logic rst2;
   logic [AW-1:0] addr2;
   logic re2, we2;
   logic [DW-1:0] wdata2;
   logic [DW-1:0] rdData2;
   logic rdy2, busy2;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          expCyc;
      bit          isRead;
      logic [DW-1:0] data;
   } sb_t;
   sb_t sbQ[$];

   typedef struct {
      logic          vRe;
      logic          vWe;
      logic [AW-1:0] vAddr;
      logic [DW-1:0] vWdata;
      logic [DW-1:0] expData;
   } vec_t;

   logic [DW-1:0] lastRead = '0;

   unified_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wdata(wdata),
      .rd_data(rdData), .rdy(rdy), .busy(busy)
   );

   unified_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst2), .addr(addr2), .re(re2), .we(we2), .wdata(wdata2),
      .rd_data(rdData2), .rdy(rdy2), .busy(busy2)
   );

   // Free-running clock and an edge counter used to timestamp rdy pulses.
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Scoreboard monitor: every rdy pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && rdy) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected rdy", 64'd1, 64'd0);
         end else begin
            sb_t e;
            e = sbQ.pop_front();
            checkOutput("rdy cycle", 64'(cyc), 64'(e.expCyc));
            checkOutput("busy during rdy", 64'(busy), 64'd1);
            checkOutput(e.isRead ? "read data" : "rd_data hold on write", rdData, e.data);
         end
      end
   end

   task automatic waitDrain(input string name);
      int n = 0;
      while (sbQ.size() != 0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sbQ.size() != 0) begin
         checkOutput({name, " rdy timeout"}, 64'(sbQ.size()), 64'd0);
         sbQ.delete();
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      sb_t e;
      @(negedge clk);
      re = v.vRe;
      we = v.vWe;
      addr = v.vAddr;
      wdata = v.vWdata;
      e.expCyc = cyc + 1 + LAT - 1;
      e.isRead = v.vRe && !v.vWe;
      if (e.isRead) lastRead = v.expData;
      e.data = lastRead;
      sbQ.push_back(e);
      @(negedge clk);
      re = 1'b0;
      we = 1'b0;
      waitDrain("vector");
   endtask

   task automatic doWrite2(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      bit seen = 0;
      @(negedge clk);
      we2 = 1'b1;
      addr2 = a;
      wdata2 = d;
      @(negedge clk);
      we2 = 1'b0;
      while (!seen && n < 10) begin
         if (rdy2) seen = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      checkOutput("lat2 write rdy", 64'(seen), 64'd1);
   endtask

   vec_t vecs[8];
   logic exp2Rdy [6];
   logic exp2Busy [6];
   logic [DW-1:0] exp2Data [6];

   initial begin
      vecs[0] = '{1'b0, 1'b1, 14'h0123, 64'hDEADBEEF_CAFEF00D, 64'h0};
      vecs[1] = '{1'b1, 1'b0, 14'h0123, 64'h0, 64'hDEADBEEF_CAFEF00D};
      vecs[2] = '{1'b0, 1'b1, 14'h0010, 64'h1010_1010_1010_1010, 64'h0};
      vecs[3] = '{1'b0, 1'b1, 14'h0011, 64'h1111_1111_1111_1111, 64'h0};
      vecs[4] = '{1'b1, 1'b1, 14'h3FFF, 64'h1, 64'h0};
      vecs[5] = '{1'b1, 1'b0, 14'h3FFF, 64'h0, 64'h1};
      vecs[6] = '{1'b0, 1'b1, 14'h3FFF, 64'hAA, 64'h0};
      vecs[7] = '{1'b1, 1'b0, 14'h0010, 64'h0, 64'h1010_1010_1010_1010};

      exp2Rdy  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp2Busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      exp2Data = '{64'h0, 64'hA0, 64'h0, 64'h0, 64'hA1, 64'h0};

      rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      rst2 = 1'b1; re2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rst2 = 1'b0;

      // Idle after reset: outputs stay quiet.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("idle rdy", 64'(rdy), 64'd0);
         checkOutput("idle busy", 64'(busy), 64'd0);
         checkOutput("idle rd_data", rdData, 64'd0);
      end

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Held read with address change: one completion for 0x0010, re-accept picks up 0x0011.
      begin
         sb_t e1, e2;
         int acc;
         @(negedge clk);
         re = 1'b1;
         addr = 14'h0010;
         acc = cyc + 1;
         e1.expCyc = acc + 3; e1.isRead = 1; e1.data = 64'h1010_1010_1010_1010;
         e2.expCyc = acc + 8; e2.isRead = 1; e2.data = 64'h1111_1111_1111_1111;
         sbQ.push_back(e1);
         sbQ.push_back(e2);
         lastRead = 64'h1111_1111_1111_1111;
         @(negedge clk);
         @(negedge clk);
         addr = 14'h0011;
         repeat (6) @(negedge clk);
         re = 1'b0;
         waitDrain("held read");
         repeat (6) @(negedge clk);
      end

      // Reset in the middle of a write: no completion and the old line survives.
      @(negedge clk);
      we = 1'b1;
      addr = 14'h3FFF;
      wdata = 64'h5555;
      @(negedge clk);
      we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lastRead = '0;
      checkOutput("busy after reset", 64'(busy), 64'd0);
      checkOutput("rdy after reset", 64'(rdy), 64'd0);
      checkOutput("rd_data after reset", rdData, 64'd0);
      repeat (6) @(negedge clk);
      applyStimulus('{1'b1, 1'b0, 14'h3FFF, 64'h0, 64'hAA});

      // LATENCY=2 build: held read, DONE cycle never accepts.
      doWrite2(14'h0000, 64'hA0);
      doWrite2(14'h0001, 64'hA1);
      repeat (2) @(negedge clk);
      re2 = 1'b1;
      addr2 = 14'h0000;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("lat2 rdy[%0d]", k), 64'(rdy2), 64'(exp2Rdy[k]));
         checkOutput($sformatf("lat2 busy[%0d]", k), 64'(busy2), 64'(exp2Busy[k]));
         if (exp2Rdy[k]) checkOutput($sformatf("lat2 data[%0d]", k), rdData2, exp2Data[k]);
         if (k == 0) addr2 = 14'h0001;
         if (k == 4) re2 = 1'b0;
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/unified_mem_responder.md
Name: unified_mem_responder

Overview:
- Responder end of the cache-controller ↔ unified-memory line interface.
- Accepts one line read or write at a time: 14-bit line address, 64-bit line data.
- Services each access after a fixed multi-cycle latency and signals completion with a one-cycle `rdy` pulse.
- Sits below the I/D cache controller as the single backing store for both caches. Replaces the behavioural memory model with a synthesizable, parameterized block.

Parameters:
- ADDR_W, 14, line address width; array depth is 2^ADDR_W lines.
- DATA_W, 64, line width in bits.
- LATENCY, 4, cycles from request acceptance to `rdy`; legal range 2..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- addr  in  ADDR_W  line address of the request.
- re  in  1  read request.
- we  in  1  write request; takes priority over `re`.
- wdata  in  DATA_W  write line data.
- rd_data  out  DATA_W  read line data.
- rdy  out  1  completion pulse.
- busy  out  1  high while a request is in flight.

Behaviour:
- Reset, while `rst`=1 at an edge:
  - state←IDLE, `rdy`←0, `busy`←0, `rd_data`←0, counter←0.
  - Array contents are not cleared.
- States:
  - IDLE: no request in flight.
  - BUSY: waiting out the latency.
  - DONE: one cycle; `rdy`=1.
- IDLE:
  - If `we`|`re` at an edge, capture `addr`, `wdata` and op, then go to BUSY. Op is WRITE if `we`=1, otherwise READ.
  - The counter loads LATENCY-1 on acceptance.
- BUSY:
  - Decrements the counter each cycle.
  - `addr`/`re`/`we`/`wdata` are ignored; the captured copies are used.
  - When the counter reaches 1, go to DONE.
- Latency: request sampled at edge 0 ⇒ `busy`=1 in cycles 1..LATENCY-1 and `rdy`=1 in cycle LATENCY. Default: `rdy` in the 4th cycle after acceptance.
- DONE, read:
  - `rd_data` shows the array line at the captured address throughout the `rdy` cycle.
  - `rd_data` then holds until the next read completes. Writes never change `rd_data`.
- DONE, write:
  - The array line is written at the edge that ends the `rdy` cycle.
  - A write aborted before DONE never modifies the array.
- DONE→IDLE unconditionally. Requests present during the DONE cycle are ignored; the earliest next acceptance is the edge after DONE. Initiators must drop or retarget `re`/`we` on `rdy`.
- `busy`=1 in BUSY and DONE, 0 in IDLE.
- Simultaneous `re`&`we` in IDLE: treated as a write; no read data is produced.
- Read after write to the same line: the next request returns the new data, with no bypass needed given DONE→IDLE spacing.
- Address wrap: `addr` is exactly ADDR_W bits; no wrap logic.
- Reset mid-operation: the request is abandoned, no `rdy` is produced, and any pending write is dropped.
- Array: synchronous read, registered output. Issue the read one cycle before DONE so data is valid in DONE.

Decomposition:
- Shared package `mem_if_pkg`:
  - ADDR_W/DATA_W defaults.
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Op encoding: OP_RD=0, OP_WR=1.
- Sub-module `line_mem_array`: single-port synchronous RAM with ports clk, en, we, addr, wdata, rdata.
- FSM, counter and capture registers stay in the top level.

Test Plan:
- Reset, then hold `re`=`we`=0 for 10 cycles → `rdy`=0, `busy`=0, `rd_data`=0 throughout.
- `we`=1, addr=0x0123, wdata=0xDEADBEEF_CAFEF00D for one cycle, then a read of 0x0123 → write `rdy` exactly 4 cycles after acceptance; read `rdy` 4 cycles after its acceptance with `rd_data`=0xDEADBEEF_CAFEF00D.
- Hold `re`=1 at addr 0x0010 for 8 cycles, changing addr to 0x0011 in cycle 2 → exactly one `rdy` (cycle 4) returning line 0x0010; request re-accepted at cycle 5, second `rdy` at cycle 9.
- `re`=`we`=1 together, addr=0x3FFF, wdata=0x1 → treated as a write; `rd_data` unchanged; a subsequent read of 0x3FFF returns 0x1.
- Write 0x3FFF=0xAA, then start a write of 0x5555 to 0x3FFF and assert `rst` in cycle 2 → no `rdy`; `busy`=0 next cycle; a read of 0x3FFF returns 0xAA.
- LATENCY=2 build: back-to-back reads of 0x0000/0x0001 → `rdy` in cycles 2 and 5; DONE cycle never accepts a request.
